// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder.
//   spi_slave_state_t : responder FSM states
//   SPI_MODE0..3      : {cpol, cpha} pairs for the four SPI modes
package spi_pkg;

  typedef enum logic [1:0] {
    wait_ss_high,
    idle,
    active
  } spi_slave_state_t;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input plus one edge-detect
// register.
//   clk, reset : system clock, synchronous active-high reset
//   d          : asynchronous input
//   q          : synchronized level
//   rise, fall : one-cycle pulses when q changes
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Chains clear to 0: a select line held low across reset reads as
  // "still selected", so the FSM cannot see a false falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign q    = chain[SYNC_STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_slave.sv
// SPI responder, oversampled in the clk domain, all four cpol/cpha modes,
// DBIT-bit frames MSb first in both directions.
//   clk, reset            : system clock, synchronous active-high reset
//   cpol, cpha            : SPI mode; change only while ss_n is high
//   din, wr_tx            : TX byte and its write strobe
//   sclk, ss_n, mosi      : asynchronous SPI link from the master
//   miso, miso_oe         : serial out and pad enable
//   dout, rx_done_tick    : last received byte and its update pulse
//   tx_ready              : TX buffer empty
//   abort_tick            : ss_n rose with a partial byte in flight
module spi_slave
  import spi_pkg::*;
#(
  parameter int DBIT        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cpol,
  input  logic            cpha,
  input  logic [DBIT-1:0] din,
  input  logic            wr_tx,
  input  logic            sclk,
  input  logic            ss_n,
  input  logic            mosi,
  output logic            miso,
  output logic            miso_oe,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            tx_ready,
  output logic            abort_tick
);

  localparam int            NW     = $clog2(DBIT + 1);
  localparam logic [NW-1:0] N_FULL = NW'(DBIT);

  logic sclk_s, sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .clk(clk), .reset(reset), .d(sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_ss (
    .clk(clk), .reset(reset), .d(ss_n), .q(ss_s), .rise(ss_rise), .fall(ss_fall)
  );
  // Same depth as sclk so mosi_s is aligned with the decoded clock edges.
  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
    .clk(clk), .reset(reset), .d(mosi), .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_ok;
  assign unused_ok = &{1'b0, sclk_s, mosi_rise, mosi_fall};

  // Leading edge leaves the idle (cpol) level, trailing edge returns to it.
  logic lead, trail, sample_e, shift_e;
  assign lead     = cpol ? sclk_fall : sclk_rise;
  assign trail    = cpol ? sclk_rise : sclk_fall;
  assign sample_e = cpha ? trail : lead;
  assign shift_e  = cpha ? lead  : trail;

  spi_slave_state_t state;
  logic [NW-1:0]    n;
  logic [DBIT-1:0]  si_reg, so_reg, tx_buf;
  logic             skip_shift;  // cpha=1: first lead edge of a frame, MSb already out
  logic             reload;      // byte finished, next shift edge loads the next TX byte

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= wait_ss_high;
      n            <= '0;
      si_reg       <= '0;
      so_reg       <= '0;
      tx_buf       <= '0;
      tx_ready     <= 1'b1;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      abort_tick   <= 1'b0;
      miso_oe      <= 1'b0;
      skip_shift   <= 1'b0;
      reload       <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      abort_tick   <= 1'b0;
      case (state)
        wait_ss_high: begin
          miso_oe <= 1'b0;
          if (ss_s) state <= idle;
        end
        idle: begin
          if (ss_fall) begin
            state      <= active;
            miso_oe    <= 1'b1;
            so_reg     <= tx_ready ? '0 : tx_buf;
            tx_ready   <= 1'b1;
            n          <= '0;
            skip_shift <= cpha;
            reload     <= 1'b0;
          end
        end
        active: begin
          if (ss_rise) begin
            state   <= idle;
            miso_oe <= 1'b0;
            n       <= '0;
            // A byte completing in the very cycle ss_n rises is still delivered.
            if (n == N_FULL) begin
              dout         <= si_reg;
              rx_done_tick <= 1'b1;
            end else if (n != '0) begin
              abort_tick <= 1'b1;
            end
          end else begin
            if (n == N_FULL) begin
              dout         <= si_reg;
              rx_done_tick <= 1'b1;
              n            <= '0;
              reload       <= 1'b1;
            end else if (sample_e) begin
              si_reg <= {si_reg[DBIT-2:0], mosi_s};
              n      <= n + 1'b1;
            end
            if (shift_e) begin
              if (reload) begin
                so_reg   <= tx_ready ? '0 : tx_buf;
                tx_ready <= 1'b1;
                reload   <= 1'b0;
              end else if (skip_shift) begin
                skip_shift <= 1'b0;
              end else begin
                so_reg <= {so_reg[DBIT-2:0], 1'b0};
              end
            end
          end
        end
        default: state <= wait_ss_high;
      endcase
      // Placed last so a write coinciding with a load keeps the new byte
      // buffered: the load above already took the old contents.
      if (wr_tx) begin
        tx_buf   <= din;
        tx_ready <= 1'b0;
      end
    end
  end

  assign miso = miso_oe & so_reg[DBIT-1];

endmodule
